// File: rtl/reverb_m2s_fifo_pkt.sv
// Avalon-MM to Avalon-ST sample FIFO for the reverb datapath: CPU pushes words, stream side pops them.
// Optional packet framing (per-entry EOP tag, SOP/EOP generation) is enabled by defining M2S_FIFO_PACKET_EN.
module reverb_m2s_fifo_pkt #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 32,
    parameter int AFULL  = DEPTH - 4,
    parameter int LVL_W  = $clog2(DEPTH) + 1
) (
    input  logic              wrclock,
    input  logic              reset_n,
    input  logic [1:0]        avalonmm_write_slave_address,
    input  logic              avalonmm_write_slave_write,
    input  logic              avalonmm_write_slave_read,
    input  logic [DATA_W-1:0] avalonmm_write_slave_writedata,
    output logic [DATA_W-1:0] avalonmm_write_slave_readdata,
    output logic              avalonmm_write_slave_waitrequest,
    output logic [DATA_W-1:0] avalonst_source_data,
    output logic              avalonst_source_valid,
    input  logic              avalonst_source_ready,
    output logic              avalonst_source_startofpacket,
    output logic              avalonst_source_endofpacket,
    output logic              almost_full
);

    localparam int AW = $clog2(DEPTH);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0]  level_q, level_d;

    logic full, empty, push, pop, flush;

    assign full  = (level_q == LVL_W'(DEPTH));
    assign empty = (level_q == '0);

    // Addresses 0 and 1 are data pushes; a flush wins over a same-cycle pop.
    assign push  = avalonmm_write_slave_write & ~avalonmm_write_slave_address[1] & ~full;
    assign flush = avalonmm_write_slave_write & (avalonmm_write_slave_address == 2'd3)
                   & avalonmm_write_slave_writedata[0];
    assign pop   = ~empty & avalonst_source_ready & ~flush;

    assign avalonmm_write_slave_waitrequest = ~reset_n
        | (full & avalonmm_write_slave_write & ~avalonmm_write_slave_address[1]);

    assign almost_full           = (level_q >= LVL_W'(AFULL));
    assign avalonst_source_valid = ~empty;
    assign avalonst_source_data  = empty ? '0 : mem_q[rd_ptr_q];

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            level_d  = '0;
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + AW'(1);
            if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
            case ({push, pop})
                2'b10:   level_d = level_q + LVL_W'(1);
                2'b01:   level_d = level_q - LVL_W'(1);
                default: level_d = level_q;
            endcase
        end
    end

    always_ff @(posedge wrclock or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

    // Storage needs no reset: the source data output is masked while empty.
    always_ff @(posedge wrclock) begin
        if (push) mem_q[wr_ptr_q] <= avalonmm_write_slave_writedata;
    end

    always_comb begin
        avalonmm_write_slave_readdata = '0;
        if (avalonmm_write_slave_read) begin
            case (avalonmm_write_slave_address)
                2'd2:    avalonmm_write_slave_readdata = DATA_W'(level_q);
                2'd3:    avalonmm_write_slave_readdata[3:1] = {almost_full, full, empty};
                default: avalonmm_write_slave_readdata = '0;
            endcase
        end
    end

`ifdef M2S_FIFO_PACKET_EN
    logic eop_mem_q [DEPTH];
    logic sop_q, sop_d;

    // The next word starts a packet after reset, after a flush, or after an EOP word leaves.
    always_comb begin
        sop_d = sop_q;
        if (flush)    sop_d = 1'b1;
        else if (pop) sop_d = eop_mem_q[rd_ptr_q];
    end

    always_ff @(posedge wrclock or negedge reset_n) begin
        if (!reset_n) sop_q <= 1'b1;
        else          sop_q <= sop_d;
    end

    always_ff @(posedge wrclock) begin
        if (push) eop_mem_q[wr_ptr_q] <= avalonmm_write_slave_address[0];
    end

    assign avalonst_source_startofpacket = ~empty & sop_q;
    assign avalonst_source_endofpacket   = ~empty & eop_mem_q[rd_ptr_q];
`else
    assign avalonst_source_startofpacket = 1'b0;
    assign avalonst_source_endofpacket   = 1'b0;
`endif

endmodule

// File: tb/tb_reverb_m2s_fifo_pkt.sv
// Directed self-checking bench for reverb_m2s_fifo_pkt (DEPTH=32, AFULL=28).
module tb_reverb_m2s_fifo_pkt;

    localparam int DATA_W = 32;
    localparam int DEPTH  = 32;
    localparam int AFULL  = 28;

    logic              clk;
    logic              reset_n;
    logic [1:0]        address;
    logic              write;
    logic              read;
    logic [DATA_W-1:0] writedata;
    logic [DATA_W-1:0] readdata;
    logic              waitrequest;
    logic [DATA_W-1:0] src_data;
    logic              src_valid;
    logic              src_ready;
    logic              src_sop;
    logic              src_eop;
    logic              almost_full;

    int n_checks = 0;
    int n_fail   = 0;

`ifdef M2S_FIFO_PACKET_EN
    localparam logic PKT = 1'b1;
`else
    localparam logic PKT = 1'b0;
`endif

    reverb_m2s_fifo_pkt #(
        .DATA_W(DATA_W),
        .DEPTH (DEPTH),
        .AFULL (AFULL)
    ) dut (
        .wrclock                          (clk),
        .reset_n                          (reset_n),
        .avalonmm_write_slave_address     (address),
        .avalonmm_write_slave_write       (write),
        .avalonmm_write_slave_read        (read),
        .avalonmm_write_slave_writedata   (writedata),
        .avalonmm_write_slave_readdata    (readdata),
        .avalonmm_write_slave_waitrequest (waitrequest),
        .avalonst_source_data             (src_data),
        .avalonst_source_valid            (src_valid),
        .avalonst_source_ready            (src_ready),
        .avalonst_source_startofpacket    (src_sop),
        .avalonst_source_endofpacket      (src_eop),
        .almost_full                      (almost_full)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic test_reset();
        reset_n = 1'b0; address = 2'd0; write = 1'b0; read = 1'b0;
        writedata = '0; src_ready = 1'b0;
        #1;
        n_checks++;
        if (waitrequest !== 1'b1) begin n_fail++; $display("[TB] FAIL reset_waitreq got %b want 1", waitrequest); end
        n_checks++;
        if ({src_valid, src_sop, src_eop, almost_full} !== 4'b0000) begin
            n_fail++; $display("[TB] FAIL reset_flags got %b want 0000", {src_valid, src_sop, src_eop, almost_full});
        end
        n_checks++;
        if (src_data !== 32'h0 || readdata !== 32'h0) begin
            n_fail++; $display("[TB] FAIL reset_data got data=%h rd=%h want 0", src_data, readdata);
        end
        @(negedge clk); @(negedge clk);
        reset_n = 1'b1;
        read = 1'b1; address = 2'd2;
        #1;
        n_checks++;
        if (readdata !== 32'd0) begin n_fail++; $display("[TB] FAIL reset_level got %0d want 0", readdata); end
        read = 1'b0;
    endtask

    task automatic test_basic_stream();
        logic [DATA_W-1:0] exp [3];
        exp[0] = 32'h11; exp[1] = 32'h22; exp[2] = 32'h33;
        @(negedge clk);
        src_ready = 1'b1; write = 1'b1; address = 2'd0; writedata = exp[0];
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            n_checks++;
            if (src_valid !== 1'b1 || src_data !== exp[i]) begin
                n_fail++; $display("[TB] FAIL basic_word%0d got v=%b d=%h want v=1 d=%h", i, src_valid, src_data, exp[i]);
            end
            if (i == 0) begin
                n_checks++;
                if (src_sop !== PKT) begin n_fail++; $display("[TB] FAIL basic_sop got %b want %b", src_sop, PKT); end
            end
            if (i < 2) writedata = exp[i+1];
            else write = 1'b0;
        end
        @(negedge clk);
        read = 1'b1; address = 2'd2;
        #1;
        n_checks++;
        if (src_valid !== 1'b0 || readdata !== 32'd0) begin
            n_fail++; $display("[TB] FAIL basic_drained got v=%b lvl=%0d want v=0 lvl=0", src_valid, readdata);
        end
        read = 1'b0; src_ready = 1'b0;
    endtask

    task automatic test_full_almost_full();
        src_ready = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            @(negedge clk);
            n_checks++;
            if (almost_full !== (i >= AFULL)) begin
                n_fail++; $display("[TB] FAIL afull_at_%0d got %b want %b", i, almost_full, (i >= AFULL));
            end
            write = 1'b1; address = 2'd0; writedata = 32'h100 + i;
            #1;
            n_checks++;
            if (waitrequest !== 1'b0) begin n_fail++; $display("[TB] FAIL fill_waitreq_%0d got %b want 0", i, waitrequest); end
        end
        @(negedge clk);
        writedata = 32'hAA;
        #1;
        n_checks++;
        if (waitrequest !== 1'b1) begin n_fail++; $display("[TB] FAIL full_stall1 got %b want 1", waitrequest); end
        @(negedge clk);
        n_checks++;
        if (waitrequest !== 1'b1) begin n_fail++; $display("[TB] FAIL full_stall2 got %b want 1", waitrequest); end
        src_ready = 1'b1;
        @(negedge clk);
        src_ready = 1'b0;
        #1;
        n_checks++;
        if (waitrequest !== 1'b0) begin n_fail++; $display("[TB] FAIL after_pop_waitreq got %b want 0", waitrequest); end
        @(negedge clk);
        write = 1'b0; read = 1'b1; address = 2'd2;
        #1;
        n_checks++;
        if (readdata !== 32'd32) begin n_fail++; $display("[TB] FAIL full_level got %0d want 32", readdata); end
        address = 2'd3;
        #1;
        n_checks++;
        if (readdata !== 32'hC) begin n_fail++; $display("[TB] FAIL full_ctrl got %h want c", readdata); end
        read = 1'b0;
        src_ready = 1'b1;
        for (int i = 0; i < DEPTH; i++) begin
            logic [DATA_W-1:0] want;
            want = (i < DEPTH - 1) ? (32'h101 + i) : 32'hAA;
            n_checks++;
            if (src_valid !== 1'b1 || src_data !== want) begin
                n_fail++; $display("[TB] FAIL drain_%0d got v=%b d=%h want v=1 d=%h", i, src_valid, src_data, want);
            end
            @(negedge clk);
        end
        n_checks++;
        if (src_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL drain_empty got %b want 0", src_valid); end
        src_ready = 1'b0;
    endtask

    task automatic test_flush();
        src_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            write = 1'b1; address = 2'd0; writedata = 32'h200 + i;
        end
        @(negedge clk);
        n_checks++;
        if (src_valid !== 1'b1 || src_data !== 32'h200) begin
            n_fail++; $display("[TB] FAIL flush_pre got v=%b d=%h want v=1 d=200", src_valid, src_data);
        end
        address = 2'd3; writedata = 32'h1; src_ready = 1'b1;
        @(negedge clk);
        write = 1'b0; src_ready = 1'b0; read = 1'b1; address = 2'd2;
        #1;
        n_checks++;
        if (src_valid !== 1'b0 || readdata !== 32'd0) begin
            n_fail++; $display("[TB] FAIL flush_post got v=%b lvl=%0d want v=0 lvl=0", src_valid, readdata);
        end
        read = 1'b0;
        @(negedge clk);
        write = 1'b1; address = 2'd0; writedata = 32'h55;
        @(negedge clk);
        write = 1'b0;
        n_checks++;
        if (src_valid !== 1'b1 || src_data !== 32'h55 || src_sop !== PKT) begin
            n_fail++; $display("[TB] FAIL flush_rewrite got v=%b d=%h sop=%b want v=1 d=55 sop=%b", src_valid, src_data, src_sop, PKT);
        end
        src_ready = 1'b1;
        @(negedge clk);
        src_ready = 1'b0;
    endtask

    task automatic test_packet_framing();
        logic [DATA_W-1:0] words [3];
        logic [1:0]        addrs [3];
        logic [1:0]        flags [3];
        words[0] = 32'hA0; words[1] = 32'hB0; words[2] = 32'hC0;
        addrs[0] = 2'd0;   addrs[1] = 2'd1;   addrs[2] = 2'd1;
        flags[0] = {PKT, 1'b0}; flags[1] = {1'b0, PKT}; flags[2] = {PKT, PKT};
        src_ready = 1'b0;
        @(negedge clk);
        write = 1'b1; address = 2'd3; writedata = 32'h1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            address = addrs[i]; writedata = words[i];
        end
        @(negedge clk);
        write = 1'b0; src_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            n_checks++;
            if (src_valid !== 1'b1 || src_data !== words[i] || {src_sop, src_eop} !== flags[i]) begin
                n_fail++;
                $display("[TB] FAIL pkt_word%0d got v=%b d=%h sop/eop=%b want v=1 d=%h sop/eop=%b",
                         i, src_valid, src_data, {src_sop, src_eop}, words[i], flags[i]);
            end
            @(negedge clk);
        end
        n_checks++;
        if (src_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL pkt_empty got %b want 0", src_valid); end
        src_ready = 1'b0;
    endtask

    task automatic test_async_reset();
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            write = 1'b1; address = 2'd0; writedata = 32'h300 + i;
        end
        @(negedge clk);
        write = 1'b0; src_ready = 1'b1;
        @(negedge clk);
        src_ready = 1'b0;
        @(negedge clk);
        src_ready = 1'b1;
        #2 reset_n = 1'b0;
        #1;
        n_checks++;
        if ({src_valid, src_sop, src_eop, almost_full, waitrequest} !== 5'b00001 || src_data !== 32'h0) begin
            n_fail++; $display("[TB] FAIL async_reset got v/s/e/af/wr=%b d=%h want 00001 d=0",
                               {src_valid, src_sop, src_eop, almost_full, waitrequest}, src_data);
        end
        src_ready = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        read = 1'b1; address = 2'd2;
        #1;
        n_checks++;
        if (readdata !== 32'd0 || src_valid !== 1'b0) begin
            n_fail++; $display("[TB] FAIL post_reset_level got lvl=%0d v=%b want 0 0", readdata, src_valid);
        end
        read = 1'b0;
    endtask

    initial begin
        test_reset();
        test_basic_stream();
        test_full_almost_full();
        test_flush();
        test_packet_framing();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
